// File: rtl/palette_loader_pkg.sv
// Shared palette definitions: loader state encoding and the default
// palette geometry used by both the loader and the lookup block.
package palette_pkg;

    localparam int DATA_WIDTH    = 10;
    localparam int RBG_SIZE      = 24;
    localparam int MAX_ITERATION = 50;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PEND
    } palette_state_t;

endpackage

// File: rtl/palette_loader_if.sv
// Colour-word stream from the host into the palette loader.
// Ports: s_valid/s_data/s_last (host -> loader), s_ready (loader -> host).
interface palette_loader_if #(
    parameter int RBG_SIZE = palette_pkg::RBG_SIZE
);
    logic                s_valid;
    logic                s_ready;
    logic [RBG_SIZE-1:0] s_data;
    logic                s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/palette_loader.sv
// Writes a streamed palette into the shadow bank of a double-buffered
// palette memory and swaps banks on a frame boundary.
// Ports: clk, rst_n (async, active-low), start, s (stream slave),
//   frame_sync, wr_en/wr_addr/wr_data/wr_bank (memory write side),
//   active_bank, busy, done, err_short, err_long.
// Build option: PALETTE_DOUBLE_BUFFER_EN selects two banks with a
//   frame-synchronous swap; without it a single bank is written in place.
module palette_loader #(
    parameter int DATA_WIDTH    = palette_pkg::DATA_WIDTH,
    parameter int RBG_SIZE      = palette_pkg::RBG_SIZE,
    parameter int MAX_ITERATION = palette_pkg::MAX_ITERATION
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    palette_loader_if.slave       s,
    input  logic                  frame_sync,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_addr,
    output logic [RBG_SIZE-1:0]   wr_data,
    output logic                  wr_bank,
    output logic                  active_bank,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    output logic                  err_long
);
    import palette_pkg::*;

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR =
        DATA_WIDTH'(MAX_ITERATION - 1);

    palette_state_t        state, state_n;
    logic [DATA_WIDTH-1:0] cnt, cnt_n;
    logic                  xfer;
    logic                  at_end;
    logic                  ready_n;
    logic                  wr_en_n;
    logic                  done_n;
    logic                  err_short_n;
    logic                  err_long_n;

`ifdef PALETTE_DOUBLE_BUFFER_EN
    logic bank;
    logic swap;
`else
    logic frame_sync_unused;
    assign frame_sync_unused = frame_sync;
`endif

    assign xfer   = s.s_valid && s.s_ready;
    assign at_end = (cnt == LAST_ADDR);
    assign busy   = (state != IDLE);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wr_en_n     = 1'b0;
        done_n      = 1'b0;
        err_short_n = 1'b0;
        err_long_n  = 1'b0;
`ifdef PALETTE_DOUBLE_BUFFER_EN
        swap        = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en_n = 1'b1;
                    cnt_n   = cnt + 1'b1;
                    if (s.s_last && at_end) begin
`ifdef PALETTE_DOUBLE_BUFFER_EN
                        state_n = PEND;
`else
                        done_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else if (s.s_last) begin
                        err_short_n = 1'b1;
                        state_n     = IDLE;
                    end else if (at_end) begin
                        // Final slot is still written; the excess is dropped.
                        err_long_n = 1'b1;
                        state_n    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && s.s_last) begin
                    state_n = IDLE;
                end
            end
            PEND: begin
`ifdef PALETTE_DOUBLE_BUFFER_EN
                if (frame_sync) begin
                    swap    = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == LOAD) || (state_n == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            s.s_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            s.s_ready <= ready_n;
            wr_en     <= wr_en_n;
            done      <= done_n;
            err_short <= err_short_n;
            err_long  <= err_long_n;
            if (wr_en_n) begin
                wr_addr <= cnt;
                wr_data <= s.s_data;
            end
        end
    end

`ifdef PALETTE_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= 1'b0;
        end else if (swap) begin
            bank <= ~bank;
        end
    end

    assign active_bank = bank;
    assign wr_bank     = ~bank;
`else
    assign active_bank = 1'b0;
    assign wr_bank     = 1'b0;
`endif

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: full load, short/long palettes,
// throttled stream, coincident frame_sync and reset during a load.
`timescale 1ns/1ps
module tb_palette_loader;

`ifdef PALETTE_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        frame_sync = 1'b0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_bank;
    logic        active_bank;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_long;

    palette_loader_if s_if ();

    palette_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .s           (s_if),
        .frame_sync  (frame_sync),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_bank     (wr_bank),
        .active_bank (active_bank),
        .busy        (busy),
        .done        (done),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-side monitor, sampled on the falling edge.
    int          cyc = 0;
    int          n_short = 0;
    int          n_long = 0;
    int          n_done = 0;
    int          long_cyc = -1;
    int          w49_cyc = -2;
    logic [9:0]  wa[$];
    logic [23:0] wd[$];
    logic        wb[$];

    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wb.push_back(wr_bank);
            if (wr_addr == 10'd49) w49_cyc = cyc;
        end
        if (err_short) n_short++;
        if (err_long) begin
            n_long++;
            long_cyc = cyc;
        end
        if (done) n_done++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        wb.delete();
        n_short  = 0;
        n_long   = 0;
        n_done   = 0;
        long_cyc = -1;
        w49_cyc  = -2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic start_load();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready_rise", 32'(s_if.s_ready), 32'd1);
    endtask

    task automatic send(input int n, input int last_idx,
                        input logic [23:0] base, input bit rnd,
                        input bit fs_last, input int abort_at);
        int idx = 0;
        int budget = 0;
        bit xf;
        while (idx < n && budget < 1000) begin
            if (idx == abort_at) begin
                s_if.s_valid = 1'b0;
                rst_n = 1'b0;
                return;
            end
            s_if.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_if.s_data  = base + 24'(idx);
            s_if.s_last  = (idx == last_idx);
            frame_sync   = fs_last && (idx == last_idx);
            xf = s_if.s_valid && s_if.s_ready;
            step();
            if (xf) idx++;
            budget++;
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        frame_sync   = 1'b0;
        chk("words_accepted", 32'(idx), 32'(n));
    endtask

    task automatic chk_writes(input int n, input logic [23:0] base);
        int bad = 0;
        chk("n_writes", 32'(wa.size()), 32'(n));
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] != 10'(i) || wd[i] != base + 24'(i) || wb[i] != DB)
                bad++;
        end
        chk("write_seq", 32'(bad), 32'd0);
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_active_bank", 32'(active_bank), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'(DB));
        chk("rst_s_ready", 32'(s_if.s_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_err_long", 32'(err_long), 32'd0);
        rst_n = 1'b1;
        step();
        clear_logs();

        // Full load, words 0x000000..0x000031
        start_load();
        chk("busy_load", 32'(busy), 32'd1);
        send(50, 49, 24'h000000, 1'b0, 1'b0, -1);
        chk("ready_fall", 32'(s_if.s_ready), 32'd0);
        chk_writes(50, 24'h000000);
        chk("full_no_err", 32'(n_short + n_long), 32'd0);
`ifdef PALETTE_DOUBLE_BUFFER_EN
        chk("pend_busy", 32'(busy), 32'd1);
        chk("pend_active", 32'(active_bank), 32'd0);
        chk("pend_done", 32'(done), 32'd0);
        repeat (9) step();
        pulse_fs();
        chk("swap_active", 32'(active_bank), 32'd1);
        chk("swap_wr_bank", 32'(wr_bank), 32'd0);
        chk("swap_done", 32'(done), 32'd1);
        step();
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_after_swap", 32'(busy), 32'd0);
`else
        chk("single_done", 32'(done), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);
        step();
        pulse_fs();
        step();
        chk("single_active", 32'(active_bank), 32'd0);
`endif
        chk("full_done_count", 32'(n_done), 32'd1);

        // Short palette: s_last on word 20
        do_reset();
        start_load();
        send(21, 20, 24'hA50000, 1'b0, 1'b0, -1);
        chk("short_pulse", 32'(err_short), 32'd1);
        chk("short_idle", 32'(busy), 32'd0);
        chk("short_ready", 32'(s_if.s_ready), 32'd0);
        step();
        chk("short_pulse_end", 32'(err_short), 32'd0);
        pulse_fs();
        step();
        chk("short_no_swap", 32'(active_bank), 32'd0);
        chk("short_no_done", 32'(n_done), 32'd0);
        chk("short_count", 32'(n_short), 32'd1);

        // Long palette: 53 words, s_last on word 52
        do_reset();
        start_load();
        send(53, 52, 24'h100000, 1'b0, 1'b0, -1);
        chk("long_idle", 32'(busy), 32'd0);
        chk("long_ready", 32'(s_if.s_ready), 32'd0);
        chk_writes(50, 24'h100000);
        chk("long_count", 32'(n_long), 32'd1);
        chk("long_timing", 32'(long_cyc), 32'(w49_cyc));
        chk("long_no_short", 32'(n_short), 32'd0);
        pulse_fs();
        step();
        chk("long_no_swap", 32'(active_bank), 32'd0);
        chk("long_no_done", 32'(n_done), 32'd0);

        // Throttled stream
        do_reset();
        start_load();
        send(50, 49, 24'h3C0000, 1'b1, 1'b0, -1);
        chk_writes(50, 24'h3C0000);
        step();
        pulse_fs();
        step();
        chk("rnd_active", 32'(active_bank), 32'(DB));
        chk("rnd_done", 32'(n_done), 32'd1);

        // frame_sync coincident with the last transfer is not honoured
        do_reset();
        start_load();
        send(50, 49, 24'h200000, 1'b0, 1'b1, -1);
        chk("fs_coincident", 32'(active_bank), 32'd0);
        repeat (4) step();
        pulse_fs();
        chk("fs_second", 32'(active_bank), 32'(DB));
        step();
        chk("fs_done", 32'(n_done), 32'd1);

        // Reset at word 30, then a normal load
        do_reset();
        start_load();
        send(50, 49, 24'h300000, 1'b0, 1'b0, 30);
        #1;
        chk("abort_ready", 32'(s_if.s_ready), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_wr_addr", 32'(wr_addr), 32'd0);
        chk("abort_wr_data", 32'(wr_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_active", 32'(active_bank), 32'd0);
        chk("abort_wr_bank", 32'(wr_bank), 32'(DB));
        step();
        rst_n = 1'b1;
        step();
        clear_logs();
        start_load();
        send(50, 49, 24'h0F0F00, 1'b0, 1'b0, -1);
        chk_writes(50, 24'h0F0F00);
        step();
        pulse_fs();
        step();
        chk("reload_active", 32'(active_bank), 32'(DB));
        chk("reload_done", 32'(n_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
